// File: rtl/render_pkg.sv
// Framebuffer geometry and pixel-to-word address helpers shared by the renderers,
// the framebuffer writer and the display scan-out.
package render_pkg;

   localparam int CORDW     = 16;
   localparam int CIDXW     = 4;
   localparam int WORDW     = 16;
   localparam int PPW       = WORDW / CIDXW;
   localparam int LANEW     = $clog2(PPW);
   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 180;
   localparam int ADDRW     = 14;
   localparam int PIXW      = $clog2(FB_WIDTH * FB_HEIGHT);

   localparam logic signed [CORDW-1:0] X_LIM = CORDW'(FB_WIDTH);
   localparam logic signed [CORDW-1:0] Y_LIM = CORDW'(FB_HEIGHT);

   typedef struct packed {
      logic [ADDRW-1:0] addr;
      logic [WORDW-1:0] data;
      logic [PPW-1:0]   be;
   } fb_word_t;

   // Sign bits reject negative coordinates; the upper bounds are signed compares.
   function automatic logic in_frame(input logic signed [CORDW-1:0] px,
                                     input logic signed [CORDW-1:0] py);
      return !px[CORDW-1] && !py[CORDW-1] && (px < X_LIM) && (py < Y_LIM);
   endfunction

   // Linear pixel index; only meaningful for coordinates inside the frame.
   function automatic logic [PIXW-1:0] pix_index(input logic signed [CORDW-1:0] px,
                                                 input logic signed [CORDW-1:0] py);
      logic [PIXW-1:0] ux;
      logic [PIXW-1:0] uy;
      ux = PIXW'(px);
      uy = PIXW'(py);
      return uy * PIXW'(FB_WIDTH) + ux;
   endfunction

   function automatic logic [ADDRW-1:0] word_addr(input logic [PIXW-1:0] pix);
      return ADDRW'(pix >> LANEW);
   endfunction

   function automatic logic [LANEW-1:0] pix_lane(input logic [PIXW-1:0] pix);
      return pix[LANEW-1:0];
   endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Two-entry synchronous FIFO with occupancy count; the head is shown on dout
// and reads as zero while empty.
module fb_wr_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   logic [1:0]   count_reg;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop && (count_reg != 2'd0);
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign do_push = push && ((count_reg != 2'd2) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   assign dout  = (count_reg != 2'd0) ? mem[rd_ptr_reg] : '0;
   assign count = count_reg;

endmodule

// File: rtl/render_fb_writer.sv
// Packs the renderer pixel stream into nibble-enabled framebuffer word writes
// and reports end of frame once every pixel has left the write port.
module render_fb_writer
   import render_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [CORDW-1:0] x,
   input  logic signed [CORDW-1:0] y,
   input  logic [CIDXW-1:0]        cidx,
   input  logic                    drawing,
   output logic                    oe,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [ADDRW-1:0]        wr_addr,
   output logic [WORDW-1:0]        wr_data,
   output logic [PPW-1:0]          wr_be,
   output logic                    frame_done
);

   logic [ADDRW-1:0] hold_addr_reg, hold_addr_next;
   logic [WORDW-1:0] hold_data_reg, hold_data_next;
   logic [PPW-1:0]   hold_mask_reg, hold_mask_next;
   logic             drawing_d_reg;
   logic             frame_pend_reg;
   logic             frame_done_reg;

   logic             in_range;
   logic [PIXW-1:0]  pix;
   logic [ADDRW-1:0] waddr;
   logic [LANEW-1:0] lane;
   logic             accept;
   logic             switch_word;
   logic             flush;
   logic             drained;
   logic             draw_fall;
   logic [WORDW-1:0] base_data;
   logic [WORDW-1:0] merged_data;
   logic [PPW-1:0]   base_mask;
   logic [PPW-1:0]   merged_mask;
   logic             push;
   fb_word_t         push_word;
   fb_word_t         head_word;
   logic [1:0]       fifo_count;

   assign in_range = in_frame(x, y);
   assign pix      = pix_index(x, y);
   assign waddr    = word_addr(pix);
   assign lane     = pix_lane(pix);

   assign oe     = !rst && (fifo_count != 2'd2);
   // Out-of-frame pixels are still consumed but never touch the packer.
   assign accept = drawing && oe && in_range;

   assign switch_word = (hold_mask_reg != '0) && (waddr != hold_addr_reg);
   assign base_data   = switch_word ? '0 : hold_data_reg;
   assign base_mask   = switch_word ? '0 : hold_mask_reg;
   assign merged_mask = base_mask | (PPW'(1) << lane);

   generate
      for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
         assign merged_data[gi*CIDXW +: CIDXW] =
            (lane == LANEW'(gi)) ? cidx : base_data[gi*CIDXW +: CIDXW];
      end
   endgenerate

   assign flush = !drawing && (hold_mask_reg != '0) && (fifo_count != 2'd2);

   // Unused lanes of the held word are kept at zero so partial words leave clean.
   always_comb begin
      hold_addr_next = hold_addr_reg;
      hold_data_next = hold_data_reg;
      hold_mask_next = hold_mask_reg;
      push           = 1'b0;
      push_word      = '{addr: hold_addr_reg, data: hold_data_reg, be: hold_mask_reg};
      if (accept) begin
         hold_addr_next = waddr;
         hold_data_next = merged_data;
         hold_mask_next = merged_mask;
         if (switch_word) begin
            push = 1'b1;
         end else if (&merged_mask) begin
            push           = 1'b1;
            push_word      = '{addr: waddr, data: merged_data, be: merged_mask};
            hold_data_next = '0;
            hold_mask_next = '0;
         end
      end else if (flush) begin
         push           = 1'b1;
         hold_data_next = '0;
         hold_mask_next = '0;
      end
   end

   assign draw_fall = drawing_d_reg && !drawing;
   assign drained   = frame_pend_reg && (hold_mask_reg == '0) && (fifo_count == 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_addr_reg  <= '0;
         hold_data_reg  <= '0;
         hold_mask_reg  <= '0;
         drawing_d_reg  <= 1'b0;
         frame_pend_reg <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         hold_addr_reg  <= hold_addr_next;
         hold_data_reg  <= hold_data_next;
         hold_mask_reg  <= hold_mask_next;
         drawing_d_reg  <= drawing;
         frame_done_reg <= drained;
         // A frame ending in the very cycle the previous one retires stays pending.
         if (drained)
            frame_pend_reg <= draw_fall;
         else if (draw_fall)
            frame_pend_reg <= 1'b1;
      end
   end

   fb_wr_fifo #(
      .W($bits(fb_word_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_word),
      .pop   (wr_valid && wr_ready),
      .dout  (head_word),
      .count (fifo_count)
   );

   assign wr_valid   = (fifo_count != 2'd0);
   assign wr_addr    = head_word.addr;
   assign wr_data    = head_word.data;
   assign wr_be      = head_word.be;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_render_fb_writer.sv
// Directed and randomized pixel streams checked against a word-level model of
// the packing rules; every observed write is compared in order.
module tb_render_fb_writer;
   import render_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic signed [CORDW-1:0] x;
   logic signed [CORDW-1:0] y;
   logic [CIDXW-1:0]        cidx;
   logic                    drawing;
   logic                    oe;
   logic                    wr_valid;
   logic                    wr_ready;
   logic [ADDRW-1:0]        wr_addr;
   logic [WORDW-1:0]        wr_data;
   logic [PPW-1:0]          wr_be;
   logic                    frame_done;

   always #5 clk = ~clk;

   render_fb_writer dut (
      .clk        (clk),
      .rst        (rst),
      .x          (x),
      .y          (y),
      .cidx       (cidx),
      .drawing    (drawing),
      .oe         (oe),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_be      (wr_be),
      .frame_done (frame_done)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_mode = 0;
   int done_cnt = 0;
   bit verbose = 1'b1;

   fb_word_t exp_q[$];
   fb_word_t obs_q[$];

   // model: one word under construction, as lane values plus used flags
   int m_addr = 0;
   int m_val[PPW];
   bit m_used[PPW];
   bit m_any = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_emit();
      fb_word_t w;
      int d = 0;
      int b = 0;
      for (int l = 0; l < PPW; l++) begin
         if (m_used[l]) begin
            d = d + (m_val[l] << (CIDXW * l));
            b = b + (1 << l);
         end
         m_used[l] = 1'b0;
         m_val[l]  = 0;
      end
      w.addr = ADDRW'(m_addr);
      w.data = WORDW'(d);
      w.be   = PPW'(b);
      exp_q.push_back(w);
      m_any = 1'b0;
   endtask

   task automatic model_pixel(input int px, input int py, input int pc);
      int p;
      int a;
      int l;
      bit full;
      if (px < 0 || px >= FB_WIDTH || py < 0 || py >= FB_HEIGHT) return;
      p = py * FB_WIDTH + px;
      a = p / PPW;
      l = p % PPW;
      if (m_any && a != m_addr) model_emit();
      m_addr    = a;
      m_val[l]  = pc;
      m_used[l] = 1'b1;
      m_any     = 1'b1;
      full = 1'b1;
      for (int k = 0; k < PPW; k++) if (!m_used[k]) full = 1'b0;
      if (full) model_emit();
   endtask

   task automatic model_reset();
      for (int l = 0; l < PPW; l++) begin
         m_used[l] = 1'b0;
         m_val[l]  = 0;
      end
      m_any = 1'b0;
      exp_q.delete();
      obs_q.delete();
   endtask

   // Write port monitor: samples just before the handshake edge.
   fb_word_t prev_word;
   bit       prev_stall = 1'b0;
   always @(negedge clk) begin
      #2;
      if (prev_stall && !rst) begin
         chk("hold_valid", 64'(wr_valid), 64'(1));
         chk("hold_word", 64'({wr_addr, wr_data, wr_be}), 64'(prev_word));
      end
      if (wr_valid && wr_ready && !rst) begin
         obs_q.push_back('{addr: wr_addr, data: wr_data, be: wr_be});
         if (verbose) $display("write addr=%0d data=%04h be=%04b", wr_addr, wr_data, wr_be);
      end
      prev_stall = wr_valid && !wr_ready && !rst;
      prev_word  = '{addr: wr_addr, data: wr_data, be: wr_be};
      if (frame_done) done_cnt++;
   end

   task automatic step();
      @(negedge clk);
      cyc++;
      case (ready_mode)
         0:       wr_ready = 1'b1;
         1:       wr_ready = (cyc % 3 == 0);
         2:       wr_ready = 1'($urandom_range(0, 1));
         default: wr_ready = 1'b0;
      endcase
   endtask

   task automatic send_pixel(input int px, input int py, input int pc);
      int budget = 0;
      step();
      x       = CORDW'(px);
      y       = CORDW'(py);
      cidx    = CIDXW'(pc);
      drawing = 1'b1;
      while (!oe && budget < 1000) begin
         step();
         budget++;
      end
      if (budget >= 1000) chk("oe_wait", 64'(oe), 64'(1));
      model_pixel(px, py, pc);
   endtask

   task automatic end_frame(input string tag);
      int budget = 0;
      int d0 = done_cnt;
      step();
      drawing = 1'b0;
      if (m_any) model_emit();
      while (done_cnt == d0 && budget < 3000) begin
         step();
         budget++;
      end
      repeat (6) step();
      chk({tag, "_frame_done_count"}, 64'(done_cnt - d0), 64'(1));
   endtask

   task automatic compare_stream(input string tag);
      int n;
      chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, "_word"}, 64'(obs_q[i]), 64'(exp_q[i]));
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      int xx;
      fb_word_t w;
      rst = 1'b1;
      drawing = 1'b0;
      x = '0;
      y = '0;
      cidx = '0;
      wr_ready = 1'b0;
      model_reset();

      // reset state
      step();
      step();
      chk("rst_wr_valid", 64'(wr_valid), 64'(0));
      chk("rst_wr_addr", 64'(wr_addr), 64'(0));
      chk("rst_wr_data", 64'(wr_data), 64'(0));
      chk("rst_wr_be", 64'(wr_be), 64'(0));
      chk("rst_frame_done", 64'(frame_done), 64'(0));
      chk("rst_oe", 64'(oe), 64'(0));
      rst = 1'b0;
      repeat (2) step();
      chk("post_rst_oe", 64'(oe), 64'(1));

      // six contiguous pixels, then flush of the partial word
      ready_mode = 0;
      for (int i = 0; i < 6; i++) send_pixel(i, 0, i + 1);
      end_frame("seq6");
      w = '{addr: 14'd0, data: 16'h4321, be: 4'b1111};
      chk("seq6_w0", 64'(obs_q[0]), 64'(w));
      w = '{addr: 14'd1, data: 16'h0065, be: 4'b0011};
      chk("seq6_w1", 64'(obs_q[1]), 64'(w));
      compare_stream("seq6");

      // clipping
      send_pixel(-1, 0, 9);
      send_pixel(320, 0, 9);
      send_pixel(2, 0, 7);
      send_pixel(0, 180, 9);
      send_pixel(0, -5, 9);
      end_frame("clip");
      w = '{addr: 14'd0, data: 16'h0700, be: 4'b0100};
      chk("clip_w0", 64'(obs_q[0]), 64'(w));
      compare_stream("clip");

      // non-contiguous pair
      send_pixel(1, 0, 3);
      send_pixel(0, 1, 5);
      end_frame("noncontig");
      w = '{addr: 14'd0, data: 16'h0030, be: 4'b0010};
      chk("noncontig_w0", 64'(obs_q[0]), 64'(w));
      w = '{addr: 14'd80, data: 16'h0005, be: 4'b0001};
      chk("noncontig_w1", 64'(obs_q[1]), 64'(w));
      compare_stream("noncontig");

      // full raster at full write bandwidth
      verbose = 1'b0;
      for (int yy = 0; yy < FB_HEIGHT; yy++)
         for (int xq = 0; xq < FB_WIDTH; xq++)
            send_pixel(xq, yy, $urandom_range(0, 15));
      end_frame("raster");
      chk("raster_count", 64'(obs_q.size()), 64'(14400));
      compare_stream("raster");
      $display("raster frame complete");

      // partial raster with the write port ready one cycle in three
      ready_mode = 1;
      for (int yy = 0; yy < 60; yy++)
         for (int xq = 0; xq < FB_WIDTH; xq++)
            send_pixel(xq, yy, $urandom_range(0, 15));
      end_frame("raster_slow");
      compare_stream("raster_slow");
      $display("slow raster frame complete");

      // random walk with clipped coordinates and random write readiness
      verbose = 1'b1;
      ready_mode = 2;
      xx = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) xx = xx + 1;
         else xx = int'($urandom_range(0, 52)) - 4;
         send_pixel(xx, int'($urandom_range(0, 6)) - 2, $urandom_range(0, 15));
      end
      end_frame("random");
      compare_stream("random");

      // reset in the middle of a frame with the FIFO full
      ready_mode = 3;
      for (int i = 0; i < 8; i++) send_pixel(i + 40, 3, i);
      step();
      chk("full_oe", 64'(oe), 64'(0));
      chk("full_valid", 64'(wr_valid), 64'(1));
      #3;
      rst = 1'b1;
      drawing = 1'b0;
      #1;
      chk("async_rst_valid", 64'(wr_valid), 64'(0));
      chk("async_rst_addr", 64'(wr_addr), 64'(0));
      chk("async_rst_data", 64'(wr_data), 64'(0));
      chk("async_rst_be", 64'(wr_be), 64'(0));
      chk("async_rst_oe", 64'(oe), 64'(0));
      chk("async_rst_done", 64'(frame_done), 64'(0));
      repeat (3) step();
      rst = 1'b0;
      model_reset();
      d0 = done_cnt;
      repeat (10) step();
      chk("rst_no_frame_done", 64'(done_cnt - d0), 64'(0));
      chk("rst_idle_valid", 64'(wr_valid), 64'(0));
      ready_mode = 0;
      for (int i = 0; i < 6; i++) send_pixel(i, 0, 10 + i);
      end_frame("after_rst");
      w = '{addr: 14'd0, data: 16'hDCBA, be: 4'b1111};
      chk("after_rst_w0", 64'(obs_q[0]), 64'(w));
      compare_stream("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
